// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// The stage_ctrl_t bit order is {pc_en, ifid_en, idex_en, exme_en, mewb_en, ifid_flush, idex_flush, mewb_flush}.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exme_en;
    logic mewb_en;
    logic ifid_flush;
    logic idex_flush;
    logic mewb_flush;
  } stage_ctrl_t;

  localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;

  localparam stage_ctrl_t CTRL_NORMAL   = 8'b11111_000;
  localparam stage_ctrl_t CTRL_REDIRECT = 8'b11111_110;
  localparam stage_ctrl_t CTRL_LOAD_USE = 8'b00111_010;
  localparam stage_ctrl_t CTRL_FREEZE   = 8'b00000_001;
  localparam stage_ctrl_t CTRL_HALTED   = 8'b00000_000;

  // The wait counter is at least 8 bits and always wide enough to hold the timeout.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter: adds one on every enabled cycle, rolls over modulo 2^CNT_W.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the five-stage pipeline: arbitrates memory freeze, EX redirect
// and load-use stall into per-stage enables/flushes, and halts on request or memory timeout.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             redirect_ex,
  input  logic             dmem_req_me,
  input  logic             dmem_ready,
  input  logic             halt_req_me,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exme_en,
  output logic             mewb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mewb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = wait_cnt_width(MEM_TIMEOUT);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              halted_q, halted_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic        active;
  logic        freeze;
  logic        redirect_hit;
  logic        load_use_hit;
  logic        timeout_hit;
  stage_ctrl_t ctrl;

  // Reset and HALT mask every event source; priority is freeze > redirect > load-use.
  assign active       = !rst && (state_q != HALT);
  assign freeze       = active && dmem_req_me && !dmem_ready;
  assign redirect_hit = active && !freeze && redirect_ex;
  assign load_use_hit = active && !freeze && !redirect_ex && load_use_stall;

  // wait_cnt_q holds the number of consecutive frozen cycles already seen, entry cycle included.
  assign timeout_hit  = (32'(wait_cnt_q) + 32'd1) >= MEM_TIMEOUT;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    ctrl = CTRL_NORMAL;
    if (!rst) begin
      if (state_q == HALT) begin
        ctrl = CTRL_HALTED;
      end else if (freeze) begin
        ctrl = CTRL_FREEZE;
      end else if (redirect_hit) begin
        ctrl = CTRL_REDIRECT;
      end else if (load_use_hit) begin
        ctrl = CTRL_LOAD_USE;
      end
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign idex_en    = ctrl.idex_en;
  assign exme_en    = ctrl.exme_en;
  assign mewb_en    = ctrl.mewb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign mewb_flush = ctrl.mewb_flush;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    halted_d      = halted_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (freeze) begin
          if (MEM_TIMEOUT <= 1) begin
            state_d       = HALT;
            halted_d      = 1'b1;
            mem_timeout_d = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end else if (halt_req_me) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end
      WAIT: begin
        if (freeze) begin
          if (timeout_hit) begin
            state_d       = HALT;
            halted_d      = 1'b1;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          wait_cnt_d = '0;
          if (halt_req_me) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (freeze || load_use_hit),
    .count (stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (redirect_hit),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with MEM_TIMEOUT=4 and CNT_W=4; control vector order is
// {pc_en, ifid_en, idex_en, exme_en, mewb_en, ifid_flush, idex_flush, mewb_flush}.
module tb_pipeline_controller;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int unsigned TB_CNT_W   = 4;

  localparam logic [7:0] V_NORMAL   = 8'hF8;
  localparam logic [7:0] V_REDIRECT = 8'hFE;
  localparam logic [7:0] V_LOAD_USE = 8'h3A;
  localparam logic [7:0] V_FREEZE   = 8'h01;
  localparam logic [7:0] V_HALTED   = 8'h00;

  logic                clk = 1'b0;
  logic                rst;
  logic                load_use_stall, redirect_ex, dmem_req_me, dmem_ready, halt_req_me;
  logic                pc_en, ifid_en, idex_en, exme_en, mewb_en;
  logic                ifid_flush, idex_flush, mewb_flush;
  logic                halted, mem_timeout;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0]          ctrl_vec;

  int checks = 0;
  int errors = 0;

  pipeline_controller #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_stall (load_use_stall),
    .redirect_ex    (redirect_ex),
    .dmem_req_me    (dmem_req_me),
    .dmem_ready     (dmem_ready),
    .halt_req_me    (halt_req_me),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exme_en        (exme_en),
    .mewb_en        (mewb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .mewb_flush     (mewb_flush),
    .halted         (halted),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_en, ifid_en, idex_en, exme_en, mewb_en, ifid_flush, idex_flush, mewb_flush};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lu, input logic rd, input logic req, input logic rdy, input logic hr);
    load_use_stall = lu;
    redirect_ex    = rd;
    dmem_req_me    = req;
    dmem_ready     = rdy;
    halt_req_me    = hr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic h, input logic mt,
                            input logic [31:0] sc, input logic [31:0] fc);
    check({tag, "_halted"}, 32'(halted), 32'(h));
    check({tag, "_timeout"}, 32'(mem_timeout), 32'(mt));
    check({tag, "_stall"}, 32'(stall_cnt), sc);
    check({tag, "_flush"}, 32'(flush_cnt), fc);
  endtask

  initial begin
    // Reset with inputs active: outputs must look like plain RUN.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_ctrl", 32'(ctrl_vec), 32'(V_NORMAL));
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_regs("reset", 1'b0, 1'b0, 0, 0);
    check("normal_ctrl", 32'(ctrl_vec), 32'(V_NORMAL));

    // Load-use, repeated on the following cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu1_ctrl", 32'(ctrl_vec), 32'(V_LOAD_USE));
    step();
    check("lu1_stall", 32'(stall_cnt), 1);
    check("lu2_ctrl", 32'(ctrl_vec), 32'(V_LOAD_USE));
    step();
    check("lu2_stall", 32'(stall_cnt), 2);

    // Redirect beats a simultaneous load-use.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("redir_lu_ctrl", 32'(ctrl_vec), 32'(V_REDIRECT));
    step();
    check_regs("redir_lu", 1'b0, 1'b0, 2, 1);

    // Memory wait: three frozen cycles (one with redirect+load-use), ready on the fourth.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("frz1_ctrl", 32'(ctrl_vec), 32'(V_FREEZE));
    step();
    check("frz1_stall", 32'(stall_cnt), 3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("frz2_ctrl", 32'(ctrl_vec), 32'(V_FREEZE));
    step();
    check_regs("frz2", 1'b0, 1'b0, 4, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("frz3_ctrl", 32'(ctrl_vec), 32'(V_FREEZE));
    step();
    check("frz3_stall", 32'(stall_cnt), 5);
    // Ready lands on what would be the timeout cycle: ready wins.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ready_ctrl", 32'(ctrl_vec), 32'(V_NORMAL));
    step();
    check_regs("ready", 1'b0, 1'b0, 5, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("post_wait_redir", 32'(ctrl_vec), 32'(V_REDIRECT));
    step();
    check("post_wait_flush", 32'(flush_cnt), 2);

    // Wait left by dropping the request; that cycle follows the load-use rule.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("req_drop_ctrl", 32'(ctrl_vec), 32'(V_LOAD_USE));
    step();
    check_regs("req_drop", 1'b0, 1'b0, 7, 2);

    // Timeout: four consecutive frozen cycles, then HALT.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("to_frz%0d_ctrl", i), 32'(ctrl_vec), 32'(V_FREEZE));
      step();
      check($sformatf("to_frz%0d_halted", i), 32'(halted), 0);
    end
    check("to_frz4_ctrl", 32'(ctrl_vec), 32'(V_FREEZE));
    step();
    check_regs("timeout", 1'b1, 1'b1, 11, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("halt_ctrl", 32'(ctrl_vec), 32'(V_HALTED));
    step();
    step();
    check("halt_hold_ctrl", 32'(ctrl_vec), 32'(V_HALTED));
    check_regs("halt_hold", 1'b1, 1'b1, 11, 2);

    // Reset out of HALT clears everything.
    rst = 1'b1;
    #1;
    check("rst_halt_ctrl", 32'(ctrl_vec), 32'(V_NORMAL));
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_regs("rst_halt", 1'b0, 1'b0, 0, 0);

    // Halt request is ignored while frozen, taken from WAIT once memory is ready.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("hr_frz_ctrl", 32'(ctrl_vec), 32'(V_FREEZE));
    step();
    check("hr_frz_halted", 32'(halted), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("hr_ctrl", 32'(ctrl_vec), 32'(V_NORMAL));
    step();
    check_regs("halt_req", 1'b1, 1'b0, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hr_halted_ctrl", 32'(ctrl_vec), 32'(V_HALTED));

    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_regs("rst_hr", 1'b0, 1'b0, 0, 0);

    // 17 redirects on a 4-bit counter wrap to 1.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step();
    end
    check("wrap_flush", 32'(flush_cnt), 1);
    check("wrap_stall", 32'(stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
